// File: rtl/bram_banked.sv
// Banked block-RAM buffer: one write port, one read port returning either a single
// word or the same row from every bank, behind a valid-tagged pipeline of latency 1 or 2.
module bram_banked #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_BANKS    = 4,
    parameter int DEPTH        = 2048,
    parameter int ADDR_WIDTH   = 20,
    parameter int OFFSET_SHIFT = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            rd_en,
    input  logic                            rd_mode,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] data_out,
    output logic                            rd_valid,
    output logic                            err,
    input  logic                            err_clr
);

    localparam int B  = $clog2(NUM_BANKS);
    localparam int BW = (B > 0) ? B : 1;
    localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = NUM_BANKS * DATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_row;
    logic [ADDR_WIDTH-1:0] rd_word;
    logic [ADDR_WIDTH-1:0] rd_row;
    logic [BW-1:0]         wr_bank;
    logic [BW-1:0]         rd_bank;
    logic                  wr_oor;
    logic                  rd_oor;

    assign wr_row  = wr_addr >> B;
    assign rd_word = rd_addr >> OFFSET_SHIFT;
    assign rd_row  = rd_word >> B;
    assign wr_bank = (B > 0) ? wr_addr[BW-1:0] : '0;
    assign rd_bank = (B > 0) ? rd_word[BW-1:0] : '0;
    assign wr_oor  = {1'b0, wr_row} >= DEPTH_W;
    assign rd_oor  = {1'b0, rd_row} >= DEPTH_W;

    logic [DATA_WIDTH-1:0] bank_rd [NUM_BANKS];

    // Each bank registers its own read word; non-blocking update gives read-first collisions.
    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [DATA_WIDTH-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (wr_en && !wr_oor && (wr_bank == BW'(i))) begin
                mem_q[wr_row[RW-1:0]] <= data_in;
            end
            if (rd_en) begin
                rd_q <= mem_q[rd_row[RW-1:0]];
            end
        end

        assign bank_rd[i] = rd_q;
    end

    logic          valid1_q;
    logic          zero1_q;
    logic          mode1_q;
    logic [BW-1:0] bank1_q;
    logic          err_q;
    logic          err_d;
    logic [OW-1:0] stage1_data;

    // Set beats clear when both happen in the same cycle.
    assign err_d = (err_q && !err_clr) || (wr_en && wr_oor) || (rd_en && rd_oor);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_q <= 1'b0;
            zero1_q  <= 1'b1;
            mode1_q  <= 1'b0;
            bank1_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            valid1_q <= rd_en;
            err_q    <= err_d;
            if (rd_en) begin
                zero1_q <= rd_oor;
                mode1_q <= rd_mode;
                bank1_q <= rd_bank;
            end
        end
    end

    // zero1_q masks the un-reset RAM registers after reset and on out-of-range reads.
    always_comb begin
        stage1_data = '0;
        if (!zero1_q) begin
            if (mode1_q) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    stage1_data[b*DATA_WIDTH +: DATA_WIDTH] = bank_rd[b];
                end
            end else begin
                stage1_data[DATA_WIDTH-1:0] = bank_rd[bank1_q];
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [OW-1:0] data2_q;
        logic          valid2_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data2_q  <= '0;
                valid2_q <= 1'b0;
            end else begin
                valid2_q <= valid1_q;
                if (valid1_q) begin
                    data2_q <= stage1_data;
                end
            end
        end

        assign data_out = data2_q;
        assign rd_valid = valid2_q;
    end else begin : g_lat1
        assign data_out = stage1_data;
        assign rd_valid = valid1_q;
    end

    assign err = err_q;

endmodule

// File: tb/tb_bram_banked.sv
// Directed bench: two instances (read latency 1 and 2) share every input so the
// same traffic checks both pipelines against hand-computed values.
module tb_bram_banked;

  logic         clk;
  logic         rst_n;
  logic         wr_en;
  logic [19:0]  wr_addr;
  logic [31:0]  data_in;
  logic         rd_en;
  logic         rd_mode;
  logic [19:0]  rd_addr;
  logic         err_clr;
  logic [127:0] data_out1;
  logic         rd_valid1;
  logic         err1;
  logic [127:0] data_out2;
  logic         rd_valid2;
  logic         err2;

  int checks_n = 0;
  int errors_n = 0;

  bram_banked #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
    .rd_en(rd_en), .rd_mode(rd_mode), .rd_addr(rd_addr), .data_out(data_out1),
    .rd_valid(rd_valid1), .err(err1), .err_clr(err_clr)
  );

  bram_banked #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .data_in(data_in),
    .rd_en(rd_en), .rd_mode(rd_mode), .rd_addr(rd_addr), .data_out(data_out2),
    .rd_valid(rd_valid2), .err(err2), .err_clr(err_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_write(input logic [19:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; data_in = d;
    cycle();
    wr_en = 1'b0;
  endtask

  // Issues one read, checks latency-1 output, then latency-2 output one cycle later.
  task automatic do_read(input string tag, input logic mode, input logic [19:0] a,
                         input logic [127:0] exp);
    rd_en = 1'b1; rd_mode = mode; rd_addr = a;
    cycle();
    rd_en = 1'b0;
    check({tag, "_v1"}, 128'(rd_valid1), 128'd1);
    check({tag, "_d1"}, data_out1, exp);
    check({tag, "_v2_early"}, 128'(rd_valid2), 128'd0);
    cycle();
    check({tag, "_v1_drop"}, 128'(rd_valid1), 128'd0);
    check({tag, "_d1_hold"}, data_out1, exp);
    check({tag, "_v2"}, 128'(rd_valid2), 128'd1);
    check({tag, "_d2"}, data_out2, exp);
  endtask

  initial begin
    rst_n = 1'b0; wr_addr = '0; data_in = '0; rd_mode = 1'b0; rd_addr = '0;
    idle();
    cycle(); cycle();
    check("rst_dout1", data_out1, 128'd0);
    check("rst_dout2", data_out2, 128'd0);
    check("rst_valid", {126'd0, rd_valid2, rd_valid1}, 128'd0);
    check("rst_err", {126'd0, err2, err1}, 128'd0);
    rst_n = 1'b1;
    cycle();

    // single-mode readback
    for (int i = 0; i < 8; i++) do_write(20'(i), 32'hA0 + 32'(i));
    for (int i = 0; i < 8; i++) do_read($sformatf("single%0d", i), 1'b0, 20'(4 * i), 128'(32'hA0 + 32'(i)));

    // wide read of row 1
    do_read("wide_row1", 1'b1, 20'h10, 128'h000000A7_000000A6_000000A5_000000A4);
    do_read("wide_row0", 1'b1, 20'h4, 128'h000000A3_000000A2_000000A1_000000A0);

    // read-first collision
    wr_en = 1'b1; wr_addr = 20'd5; data_in = 32'h55;
    rd_en = 1'b1; rd_mode = 1'b0; rd_addr = 20'h14;
    cycle();
    idle();
    check("coll_old", data_out1, 128'hA5);
    cycle();
    do_read("coll_new", 1'b0, 20'h14, 128'h55);

    // out-of-range write is dropped and sets err
    do_write(20'd8192, 32'hDEAD);
    check("oor_wr_err1", 128'(err1), 128'd1);
    check("oor_wr_err2", 128'(err2), 128'd1);
    do_read("oor_wr_mem", 1'b0, 20'h0, 128'hA0);
    check("err_sticky", 128'(err1), 128'd1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("err_clr", 128'(err1), 128'd0);

    // out-of-range read: zero data, valid still asserted, err set
    do_read("oor_rd", 1'b0, 20'h8000, 128'd0);
    check("oor_rd_err", 128'(err1), 128'd1);

    // set wins over clear in the same cycle
    err_clr = 1'b1; rd_en = 1'b1; rd_addr = 20'h8000;
    cycle();
    idle();
    check("set_wins", 128'(err1), 128'd1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("clr_again", 128'(err1), 128'd0);

    // back-to-back reads through the latency-2 pipeline
    for (int k = 0; k < 8; k++) begin
      rd_en = (k < 4); rd_mode = 1'b0; rd_addr = 20'(4 * k);
      cycle();
      check($sformatf("burst_v2_%0d", k), 128'(rd_valid2), (k >= 1 && k <= 4) ? 128'd1 : 128'd0);
      check($sformatf("burst_v1_%0d", k), 128'(rd_valid1), (k < 4) ? 128'd1 : 128'd0);
      if (k >= 1 && k <= 4) check($sformatf("burst_d2_%0d", k), data_out2, 128'(32'hA0 + 32'(k - 1)));
    end
    idle();
    check("burst_d2_hold", data_out2, 128'hA3);

    // reset lands while reads are in flight
    rd_en = 1'b1; rd_addr = 20'h4;
    cycle();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("rstmid_v_%0d", k), {126'd0, rd_valid2, rd_valid1}, 128'd0);
      check($sformatf("rstmid_d2_%0d", k), data_out2, 128'd0);
      check($sformatf("rstmid_d1_%0d", k), data_out1, 128'd0);
    end
    idle();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      check($sformatf("post_rst_v_%0d", k), {126'd0, rd_valid2, rd_valid1}, 128'd0);
      check($sformatf("post_rst_d2_%0d", k), data_out2, 128'd0);
    end
    do_read("mem_kept", 1'b0, 20'h0, 128'hA0);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
